// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counter producing registered x/y, bright, hsync, vsync and frame_tick.
// Define VGA_PIX_DIV2_EN to advance pixels every second clk (50 MHz clk, 25 MHz pixel rate).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_en,
    output logic       frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic POL = 1'(SYNC_POL);
    logic [9:0] r_x, r_y;
    logic       r_bright, r_hsync, r_vsync, r_tick;
    logic [9:0] w_x_nxt, w_y_nxt;
    logic       w_pix, w_h_end, w_v_end;
`ifdef VGA_PIX_DIV2_EN
    logic r_div;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_div <= 1'b0;
        else         r_div <= ~r_div;
    assign w_pix = r_div;
`else
    assign w_pix = 1'b1;
`endif
    // Status outputs are derived from the next position so they stay aligned with x/y.
    always_comb begin
        w_h_end = r_x == 10'(H_TOTAL - 1);
        w_v_end = r_y == 10'(V_TOTAL - 1);
        w_x_nxt = !w_pix ? r_x : w_h_end ? 10'd0 : r_x + 10'd1;
        w_y_nxt = !(w_pix && w_h_end) ? r_y : w_v_end ? 10'd0 : r_y + 10'd1;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_x      <= 10'(H_TOTAL - 1);
            r_y      <= 10'(V_TOTAL - 1);
            r_bright <= 1'b0;
            r_hsync  <= ~POL;
            r_vsync  <= ~POL;
            r_tick   <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_bright <= (w_x_nxt < 10'(H_ACTIVE)) && (w_y_nxt < 10'(V_ACTIVE));
            r_hsync  <= (w_x_nxt >= 10'(H_ACTIVE + H_FP) && w_x_nxt < 10'(H_ACTIVE + H_FP + H_SYNC)) ? POL : ~POL;
            r_vsync  <= (w_y_nxt >= 10'(V_ACTIVE + V_FP) && w_y_nxt < 10'(V_ACTIVE + V_FP + V_SYNC)) ? POL : ~POL;
            r_tick   <= w_pix && w_h_end && w_v_end;
        end
    assign x          = r_x;
    assign y          = r_y;
    assign bright     = r_bright;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = r_tick;
    assign pix_en     = w_pix;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default and small-raster timing generators.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [9:0] d_x, d_y, s_x, s_y, p_x, p_y;
    logic d_b, d_h, d_v, d_pe, d_t;
    logic s_b, s_h, s_v, s_pe, s_t;
    logic p_b, p_h, p_v, p_pe, p_t;
    int passed = 0;
    int total = 0;
    always #5 clk = ~clk;
    vga_timing_gen u_def (.clk(clk), .resetn(resetn), .x(d_x), .y(d_y), .bright(d_b),
        .hsync(d_h), .vsync(d_v), .pix_en(d_pe), .frame_tick(d_t));
    // 16x8 raster: active 8x4, hsync x=10..12, vsync y=5..6, 128 clks per frame
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_sm (.clk(clk), .resetn(resetn),
        .x(s_x), .y(s_y), .bright(s_b), .hsync(s_h), .vsync(s_v), .pix_en(s_pe), .frame_tick(s_t));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)) u_sp (.clk(clk), .resetn(resetn),
        .x(p_x), .y(p_y), .bright(p_b), .hsync(p_h), .vsync(p_v), .pix_en(p_pe), .frame_tick(p_t));

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({d_x, d_y, d_b, d_h, d_v, d_t} !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_def: x=%0d y=%0d b=%b h=%b v=%b t=%b, want 799 524 0 1 1 0", d_x, d_y, d_b, d_h, d_v, d_t);
        else passed++;
        total++;
        if ({s_x, s_y, p_h, p_v, p_b, p_t} !== {10'd15, 10'd7, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_small: x=%0d y=%0d ph=%b pv=%b pb=%b pt=%b, want 15 7 0 0 0 0", s_x, s_y, p_h, p_v, p_b, p_t);
        else passed++;
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if ({d_x, d_y, d_b, d_t, d_pe} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1})
            $display("FAIL clk1: x=%0d y=%0d b=%b t=%b pe=%b, want 0 0 1 1 1", d_x, d_y, d_b, d_t, d_pe);
        else passed++;
        @(negedge clk);
        total++;
        if ({d_x, d_y, d_t} !== {10'd1, 10'd0, 1'b0})
            $display("FAIL clk2: x=%0d y=%0d t=%b, want 1 0 0", d_x, d_y, d_t);
        else passed++;
    endtask

    // Runs 1101 pixels from reset: line 0, the 799->0 wrap, and up to x=300 on line 1.
    task automatic test_line();
        int hlow = 0;
        int bad = 0;
        do_reset();
        for (int k = 0; k <= 1100; k++) begin
            int ex, ey;
            logic eb, eh, et;
            @(negedge clk);
            ex = k % 800;
            ey = k / 800;
            eb = ex < 640;
            eh = !(ex >= 656 && ex < 752);
            et = k == 0;
            if (ey == 0 && !d_h) hlow++;
            total++;
            if ({d_x, d_y, d_b, d_h, d_v, d_t, d_pe} !== {10'(ex), 10'(ey), eb, eh, 1'b1, et, 1'b1}) begin
                if (bad < 8)
                    $display("FAIL line k=%0d: x=%0d y=%0d b=%b h=%b v=%b t=%b, want %0d %0d %b %b 1 %b",
                        k, d_x, d_y, d_b, d_h, d_v, d_t, ex, ey, eb, eh, et);
                bad++;
            end else passed++;
        end
        total++;
        if (hlow !== 96) $display("FAIL hsync_width: got %0d, want 96", hlow);
        else passed++;
    endtask

    task automatic test_async_reset();
        total++;
        if ({d_x, d_y} !== {10'd300, 10'd1}) $display("FAIL pre_async: x=%0d y=%0d, want 300 1", d_x, d_y);
        else passed++;
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({d_x, d_y, d_b, d_h, d_v, d_t} !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0})
            $display("FAIL async_reset: x=%0d y=%0d b=%b h=%b v=%b t=%b, want 799 524 0 1 1 0", d_x, d_y, d_b, d_h, d_v, d_t);
        else passed++;
    endtask

    task automatic test_frame();
        int ticks = 0;
        int brights = 0;
        int vlow = 0;
        int bad = 0;
        do_reset();
        for (int k = 0; k < 384; k++) begin
            int ex, ey;
            logic eb, eh, ev, et;
            @(negedge clk);
            ex = k % 16;
            ey = (k / 16) % 8;
            eb = ex < 8 && ey < 4;
            eh = !(ex >= 10 && ex < 13);
            ev = !(ey >= 5 && ey < 7);
            et = (k % 128) == 0;
            if (s_t) ticks++;
            if (k < 128 && s_b) brights++;
            if (k < 128 && !s_v) vlow++;
            total++;
            if ({s_x, s_y, s_b, s_h, s_v, s_t, p_h, p_v, p_b, p_t} !== {10'(ex), 10'(ey), eb, eh, ev, et, ~eh, ~ev, eb, et}) begin
                if (bad < 8)
                    $display("FAIL frame k=%0d: x=%0d y=%0d b=%b h=%b v=%b t=%b ph=%b pv=%b, want %0d %0d %b %b %b %b %b %b",
                        k, s_x, s_y, s_b, s_h, s_v, s_t, p_h, p_v, ex, ey, eb, eh, ev, et, ~eh, ~ev);
                bad++;
            end else passed++;
        end
        total++;
        if (ticks !== 3) $display("FAIL tick_count: got %0d, want 3", ticks);
        else passed++;
        total++;
        if (brights !== 32) $display("FAIL bright_count: got %0d, want 32", brights);
        else passed++;
        total++;
        if (vlow !== 32) $display("FAIL vsync_width: got %0d, want 32", vlow);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_line();
        test_async_reset();
        test_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, asserted level of hsync and vsync.
REQ-010 Port clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-011 Port resetn, input, 1, asynchronous active-low reset.
REQ-012 Port x, output, 10, current pixel column (0..H_TOTAL-1).
REQ-013 Port y, output, 10, current line (0..V_TOTAL-1).
REQ-014 Port bright, output, 1, high while (x,y) is inside the visible area.
REQ-015 Port hsync, output, 1, horizontal sync to the monitor.
REQ-016 Port vsync, output, 1, vertical sync to the monitor.
REQ-017 Port pix_en, output, 1, one-clk strobe marking each pixel advance.
REQ-018 Port frame_tick, output, 1, one-clk pulse on wrap to (0,0), used by game logic.

Function
REQ-019 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-020 x, y, bright, hsync, vsync and frame_tick SHALL be registered, and all SHALL change on the same clk edge.
REQ-021 On each clk with pix_en high: if x<H_TOTAL-1 then x+1; otherwise x=0 and y advances.
REQ-022 y advance: if y<V_TOTAL-1 then y+1; otherwise y=0.
REQ-023 x and y SHALL hold when pix_en is low.
REQ-024 bright SHALL be 1 iff x<H_ACTIVE and y<V_ACTIVE, evaluated on the new x,y.
REQ-025 hsync SHALL be SYNC_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751); otherwise ~SYNC_POL.
REQ-026 vsync SHALL be SYNC_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491); otherwise ~SYNC_POL.
REQ-027 frame_tick SHALL be 1 for exactly the clk in which x,y first read (0,0) after the wrap from (H_TOTAL-1,V_TOTAL-1); it SHALL be 0 otherwise.
REQ-028 Counters SHALL never exceed H_TOTAL-1 or V_TOTAL-1; no other wrap path is permitted.
REQ-029 All arithmetic SHALL be 10-bit unsigned; the parameters SHALL satisfy H_TOTAL<=1024 and V_TOTAL<=1024.

Reset
REQ-030 While resetn=0: x=H_TOTAL-1, y=V_TOTAL-1, bright=0, hsync=~SYNC_POL, vsync=~SYNC_POL, frame_tick=0, and the pix_en divider is cleared.
REQ-031 The first pix_en after resetn rises SHALL move to (0,0) with bright=1 and frame_tick=1.
REQ-032 Reset asserted mid-frame SHALL take effect immediately, without waiting for clk.

Configuration
REQ-033 Macro VGA_PIX_DIV2_EN defined: pix_en SHALL toggle every clk, being 0 in the first clk after reset and then 1,0,1,... (for a 50 MHz clk with a 25 MHz pixel rate).
REQ-034 Macro VGA_PIX_DIV2_EN undefined: pix_en SHALL be constant 1 after reset (for a clk that is already the pixel clock).
REQ-035 The macro SHALL NOT change any port, parameter, or the counter-relative timing.

Verification
REQ-036 Reset release, macro undefined, defaults -> at clk 1 x=0, y=0, bright=1, frame_tick=1; at clk 2 x=1, frame_tick=0.
REQ-037 Run one line -> bright falls when x=640; hsync=0 for x=656..751 (96 clks); x wraps 799->0 while y increments.
REQ-038 Run one full frame -> vsync=0 on y=490..491 only; frame_tick pulses once every 420000 clks; bright is high on 307200 clks per frame.
REQ-039 Macro defined -> x advances every 2nd clk; one frame spans 840000 clks; x,y never change on a clk where pix_en=0.
REQ-040 Assert resetn=0 at x=300, y=200 with no clk edge -> outputs immediately read x=799, y=524, bright=0, hsync=1, vsync=1.
REQ-041 SYNC_POL=1 -> hsync=1 only on x=656..751 and vsync=1 only on y=490..491; reset values of hsync and vsync are 0.
